prg_bus_mapper: RTL and testbench

PRG_BUS_MAPPER -- requirements
Module: prg_bus_mapper

---
 rtl/prg_bus_mapper.sv | 145 ++++++++++++++
 tb/tb_prg_bus_mapper.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_bus_mapper.sv
// CPU bus decoder for the PRG side of a UxROM-style cartridge: internal RAM mirror,
// PPU/APU register ports with ack timeout, banked PRG ROM and open-bus handling.
module prg_bus_mapper #(
    parameter  int RAM_AW     = 11,
    parameter  int PRG_BANKS  = 8,
    parameter  int ROM_LAT    = 1,
    parameter  int IO_TIMEOUT = 15,
    localparam int BANK_W     = (PRG_BANKS > 1) ? $clog2(PRG_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_wr,
    input  logic [15:0]          cpu_addr,
    input  logic [7:0]           cpu_wdata,
    output logic [7:0]           cpu_rdata,
    output logic                 cpu_ack,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic [7:0]           ram_wdata,
    output logic                 ram_we,
    input  logic [7:0]           ram_rdata,
    output logic [BANK_W+13:0]   rom_addr,
    input  logic [7:0]           rom_rdata,
    output logic                 io_req,
    output logic                 io_wr,
    output logic                 io_sel,
    output logic [4:0]           io_addr,
    output logic [7:0]           io_wdata,
    input  logic [7:0]           io_rdata,
    input  logic                 io_ack,
    output logic [BANK_W-1:0]    bank,
    output logic                 timeout_err
);

    // state  | meaning
    // IDLE   | waiting for cpu_req; also the cycle cpu_ack is high
    // RAM    | two cycles: address/write strobe, then sync RAM data capture
    // ROM    | counting down the PRG ROM read latency
    // IO     | io_req held until io_ack or the timeout counter expires
    // DONE   | open bus or bank-register write, completes next edge
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RAM  = 3'd1;
    localparam logic [2:0] S_ROM  = 3'd2;
    localparam logic [2:0] S_IO   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [BANK_W-1:0] TOP_BANK = BANK_W'(PRG_BANKS - 1);

    logic [2:0]  state;
    logic [14:0] addr_q;
    logic        wr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  cnt;

    assign ram_addr  = addr_q[RAM_AW-1:0];
    assign ram_wdata = wdata_q;
    assign ram_we    = (state == S_RAM) && wr_q && (cnt == 8'd1);

    // $C000-$FFFF is fixed to the last bank; $8000-$BFFF follows the bank register
    assign rom_addr  = {(addr_q[14] ? TOP_BANK : bank), addr_q[13:0]};

    assign io_req    = (state == S_IO);
    assign io_wr     = wr_q;
    assign io_sel    = addr_q[14];
    assign io_addr   = addr_q[14] ? addr_q[4:0] : {2'b00, addr_q[2:0]};
    assign io_wdata  = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bank        <= '0;
            cpu_rdata   <= 8'h00;
            cpu_ack     <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= 8'd0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= 8'h00;
        end else begin
            cpu_ack     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr[14:0];
                        wr_q    <= cpu_wr;
                        wdata_q <= cpu_wdata;
                        if (cpu_addr < 16'h2000) begin
                            state <= S_RAM;
                            cnt   <= 8'd1;
                        end else if (cpu_addr < 16'h4020) begin
                            state <= S_IO;
                            cnt   <= 8'(IO_TIMEOUT - 1);
                        end else if (cpu_addr < 16'h8000) begin
                            state <= S_DONE;
                        end else if (cpu_wr) begin
                            bank  <= (PRG_BANKS > 1) ? cpu_wdata[BANK_W-1:0] : '0;
                            state <= S_DONE;
                        end else begin
                            state <= S_ROM;
                            cnt   <= 8'(ROM_LAT);
                        end
                    end
                end
                S_RAM: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        if (!wr_q) cpu_rdata <= ram_rdata;
                        cpu_ack <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_ROM: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        cpu_rdata <= rom_rdata;
                        cpu_ack   <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_IO: begin
                    if (io_ack) begin
                        if (!wr_q) cpu_rdata <= io_rdata;
                        cpu_ack <= 1'b1;
                        state   <= S_IDLE;
                    end else if (cnt == 8'd0) begin
                        timeout_err <= 1'b1;
                        cpu_ack     <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    cpu_ack <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prg_bus_mapper.sv
// Bench for prg_bus_mapper: transaction-level reference model of the CPU memory map,
// with RAM, ROM and register-port responders around the DUT.
module tb_prg_bus_mapper;

    localparam int RAM_AW     = 11;
    localparam int PRG_BANKS  = 8;
    localparam int ROM_LAT    = 3;
    localparam int IO_TIMEOUT = 15;

    logic        clk, rst;
    logic        cpu_req, cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_we;
    logic [16:0] rom_addr;
    logic [7:0]  rom_rdata;
    logic        io_req, io_wr, io_sel, io_ack;
    logic [4:0]  io_addr;
    logic [7:0]  io_wdata, io_rdata;
    logic [2:0]  bank;
    logic        timeout_err;

    prg_bus_mapper #(
        .RAM_AW(RAM_AW), .PRG_BANKS(PRG_BANKS), .ROM_LAT(ROM_LAT), .IO_TIMEOUT(IO_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .io_req(io_req), .io_wr(io_wr), .io_sel(io_sel), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
        .bank(bank), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0] mem_m [2048];
    logic [2:0] bank_m;
    logic [7:0] rdata_m;

    // environment: sync RAM, pipelined ROM, register-port responder
    logic [7:0]  env_ram [2048];
    logic [16:0] rom_pipe [ROM_LAT];

    function automatic logic [7:0] rom_byte(input logic [16:0] a);
        return a[7:0] ^ {a[16:14], a[12:8]} ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (ram_we) env_ram[ram_addr] <= ram_wdata;
        ram_rdata <= env_ram[ram_addr];
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_rdata = rom_byte(rom_pipe[ROM_LAT-1]);

    int         io_delay = 1000;
    logic [7:0] io_val   = 8'h00;
    int         io_cnt   = 0;
    bit         io_done  = 1'b0;

    always @(negedge clk) begin
        if (io_req && !io_done) begin
            if (io_cnt == io_delay) begin
                io_ack   = 1'b1;
                io_rdata = io_val;
                io_done  = 1'b1;
            end else begin
                io_cnt++;
            end
        end else begin
            io_ack = 1'b0;
            if (!io_req) begin
                io_cnt  = 0;
                io_done = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // One CPU access; entered and left on a negedge, leaving at the ack cycle so that
    // the next call is accepted back-to-back.
    task automatic do_txn(input logic [15:0] a, input bit w, input logic [7:0] d,
                          input int iod, input logic [7:0] iov);
        int         kind;   // 0 RAM, 1 ROM, 2 IO, 3 completes immediately
        int         lat;
        bit         to;
        logic [16:0] exp_rom;
        logic [4:0]  exp_io_addr;
        bit          exp_sel;
        to = 1'b0;
        exp_io_addr = 5'd0;
        exp_sel = 1'b0;
        exp_rom = (a >= 16'hC000) ? {3'(PRG_BANKS - 1), a[13:0]} : {bank_m, a[13:0]};
        if (a < 16'h2000) begin
            kind = 0; lat = 2;
        end else if (a < 16'h4020) begin
            kind = 2;
            exp_sel = (a >= 16'h4000);
            exp_io_addr = exp_sel ? a[4:0] : {2'b00, a[2:0]};
            to  = (iod >= IO_TIMEOUT);
            lat = to ? IO_TIMEOUT : iod + 1;
        end else if (a < 16'h8000 || w) begin
            kind = 3; lat = 1;
        end else begin
            kind = 1; lat = 1 + ROM_LAT;
        end
        io_delay  = iod;
        io_val    = iov;
        cpu_req   = 1'b1;
        cpu_addr  = a;
        cpu_wr    = w;
        cpu_wdata = d;
        @(posedge clk);
        for (int j = 0; j <= lat; j++) begin
            @(negedge clk);
            if (j == lat) begin
                if (kind == 0 && w)  mem_m[a[10:0]] = d;
                if (kind == 0 && !w) rdata_m = mem_m[a[10:0]];
                if (kind == 1)       rdata_m = rom_byte(exp_rom);
                if (kind == 2 && !w && !to) rdata_m = iov;
                if (kind == 3 && w && a >= 16'h8000) bank_m = d[2:0];
            end
            chk("cpu_ack", cpu_ack, (j == lat));
            chk("timeout_err", timeout_err, (to && j == lat));
            chk("ram_we", ram_we, (kind == 0 && w && j == 0));
            chk("io_req", io_req, (kind == 2 && j < lat));
            chk("cpu_rdata", cpu_rdata, rdata_m);
            if (j == 0 && kind == 0) begin
                chk("ram_addr", ram_addr, a[10:0]);
                if (w) chk("ram_wdata", ram_wdata, d);
            end
            if (j == 0 && kind == 1) chk("rom_addr", rom_addr, exp_rom);
            if (kind == 2 && j < lat) begin
                chk("io_addr", io_addr, exp_io_addr);
                chk("io_sel", io_sel, exp_sel);
                chk("io_wr", io_wr, w);
                if (w) chk("io_wdata", io_wdata, d);
            end
            if (j == lat) chk("bank", bank, bank_m);
            if (j < lat) begin
                // noise while busy must be ignored
                cpu_req   = 1'($urandom_range(0, 1));
                cpu_addr  = 16'($urandom);
                cpu_wr    = 1'($urandom_range(0, 1));
                cpu_wdata = 8'($urandom);
            end else begin
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic abort_test(input logic [15:0] a, input bit is_io);
        io_delay = 1000;
        cpu_req  = 1'b1;
        cpu_addr = a;
        cpu_wr   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        if (is_io) chk("io_req_before_rst", io_req, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bank_m  = 3'd0;
        rdata_m = 8'h00;
        chk("rst_io_req", io_req, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_bank", bank, 0);
        chk("rst_rdata", cpu_rdata, 0);
        for (int k = 0; k < 6; k++) begin
            chk("rst_no_ack", cpu_ack, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        int          r;
        for (int i = 0; i < 2048; i++) begin
            mem_m[i]   = 8'h00;
            env_ram[i] = 8'h00;
        end
        bank_m    = 3'd0;
        rdata_m   = 8'h00;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        io_ack    = 1'b0;
        io_rdata  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", cpu_ack, 0);
        chk("reset_rdata", cpu_rdata, 8'h00);
        chk("reset_bank", bank, 0);
        chk("reset_ram_we", ram_we, 0);
        chk("reset_io_req", io_req, 0);
        chk("reset_timeout", timeout_err, 0);
        rst = 1'b0;

        // RAM mirror
        do_txn(16'h0005, 1'b1, 8'h3C, 0, 8'h00);
        do_txn(16'h1805, 1'b0, 8'h00, 0, 8'h00);
        chk("mirror_rdata", cpu_rdata, 8'h3C);
        chk("mirror_ram_addr", ram_addr, 11'h005);

        // bank switching and fixed upper window
        do_txn(16'h8000, 1'b1, 8'h0A, 0, 8'h00);
        chk("bank_write", bank, 3'd2);
        do_txn(16'h8123, 1'b0, 8'h00, 0, 8'h00);
        chk("rom_lo_addr", rom_addr, 17'h08123);
        do_txn(16'hC123, 1'b0, 8'h00, 0, 8'h00);
        chk("rom_hi_addr", rom_addr, 17'h1C123);

        // PPU register read with a slow ack, then APU register timing out
        do_txn(16'h2002, 1'b0, 8'h00, 4, 8'h80);
        chk("ppu_io_addr", io_addr, 5'h02);
        chk("ppu_io_sel", io_sel, 0);
        chk("ppu_rdata", cpu_rdata, 8'h80);
        do_txn(16'h4016, 1'b0, 8'h00, 1000, 8'hFF);
        chk("timeout_rdata", cpu_rdata, 8'h80);

        // reset during a ROM wait, then an open-bus read
        abort_test(16'h8123, 1'b0);
        do_txn(16'h6000, 1'b0, 8'h00, 0, 8'h00);
        chk("openbus_rdata", cpu_rdata, 8'h00);
        chk("openbus_bank", bank, 0);
        abort_test(16'h2007, 1'b1);

        // back-to-back RAM reads with cpu_req effectively held
        do_txn(16'h0010, 1'b1, 8'hA5, 0, 8'h00);
        for (int k = 0; k < 4; k++) do_txn(16'h0010, 1'b0, 8'h00, 0, 8'h00);
        chk("b2b_rdata", cpu_rdata, 8'hA5);

        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 5);
            case (r)
                0, 1: a = 16'($urandom_range(0, 7)) | (16'($urandom_range(0, 3)) << 11);
                2:    a = 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
                3:    a = 16'h4000 + 16'($urandom_range(0, 31));
                4:    a = 16'($urandom_range(16'h4020, 16'h7FFF));
                default: a = 16'($urandom_range(16'h8000, 16'hFFFF));
            endcase
            do_txn(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 17),
                   8'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
